// File: rtl/bomberman_map_pkg.sv
// Map geometry, tile encoding and write-requester indices shared by the
// map memory, its write arbiter and the tile producers.
package bomberman_map_pkg;

  localparam int MAP_NUM_ROW    = 11;
  localparam int MAP_NUM_COL    = 19;
  localparam int MAP_DEPTH      = MAP_NUM_ROW * MAP_NUM_COL;
  localparam int MAP_ADDR_WIDTH = 8;
  localparam int MAP_MEM_WIDTH  = 2;

  typedef enum logic [MAP_MEM_WIDTH-1:0] {
    FREE  = 2'd0,
    WALL  = 2'd1,
    BLOCK = 2'd2,
    BOMB  = 2'd3
  } tile_t;

  localparam int WR_P1_BOMB = 0;
  localparam int WR_P2_BOMB = 1;
  localparam int WR_P1_FREE = 2;
  localparam int WR_P2_FREE = 3;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of valid at or above ptr, wrapping.
// Purely combinational so read and write arbiters can share it.
module rr_pick #(
  parameter int NUM_WR = 4,
  parameter int IDX_W  = $clog2(NUM_WR)
) (
  input  logic [NUM_WR-1:0] valid,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_WR-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_pos;
  logic             w_found;

  // One extra bit on the sum lets the wrap work for non power-of-two NUM_WR.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    w_pos     = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      w_sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NUM_WR)) begin
        w_sum = w_sum - (IDX_W+1)'(NUM_WR);
      end
      w_pos = w_sum[IDX_W-1:0];
      if (!w_found && valid[w_pos]) begin
        w_found      = 1'b1;
        grant[w_pos] = 1'b1;
        grant_idx    = w_pos;
      end
    end
  end

endmodule

// File: rtl/map_write_arbiter.sv
// Captures single-cycle map write pulses into per-port holding slots and
// drains them round-robin, one registered write per cycle, into map_mem.
module map_write_arbiter
  import bomberman_map_pkg::*;
#(
  parameter  int NUM_WR    = 4,
  parameter  int ADDR_W    = MAP_ADDR_WIDTH,
  parameter  int DATA_W    = MAP_MEM_WIDTH,
  parameter  int MAP_DEPTH = bomberman_map_pkg::MAP_DEPTH,
  localparam int IDX_W     = $clog2(NUM_WR)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        wr_req,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_req,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_req,
  output logic [NUM_WR-1:0]        wr_ready,
  input  logic                     overflow_clr,
  output logic [NUM_WR-1:0]        overflow,
  output logic [NUM_WR-1:0]        bad_addr,
  output logic                     we,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic [IDX_W-1:0]         grant_idx
);

  logic [NUM_WR-1:0] r_valid;
  logic [ADDR_W-1:0] r_addr [NUM_WR];
  logic [DATA_W-1:0] r_data [NUM_WR];
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [NUM_WR-1:0] r_overflow;
  logic [NUM_WR-1:0] r_bad_addr;
  logic              r_we;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [IDX_W-1:0]  r_grant_idx;

  logic [NUM_WR-1:0] w_grant;
  logic [IDX_W-1:0]  w_grant_idx;
  logic [IDX_W-1:0]  w_ptr_next;
  logic              w_any_grant;
  logic [NUM_WR-1:0] w_ready;
  logic [NUM_WR-1:0] w_addr_ok;
  logic [NUM_WR-1:0] w_capture;
  logic [NUM_WR-1:0] w_ovf_set;
  logic [NUM_WR-1:0] w_bad_set;

  rr_pick #(
    .NUM_WR (NUM_WR),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .valid     (r_valid),
    .ptr       (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign w_any_grant = |w_grant;
  // A slot being drained this cycle can accept a new pulse on the same edge.
  assign w_ready     = ~r_valid | w_grant;
  assign w_ptr_next  = (w_grant_idx == IDX_W'(NUM_WR-1)) ? '0 : w_grant_idx + IDX_W'(1);

  always_comb begin
    w_addr_ok = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      w_addr_ok[i] = int'(wr_addr_req[i*ADDR_W +: ADDR_W]) < MAP_DEPTH;
    end
  end

  // An out-of-range address is only flagged as bad, never as overflow.
  assign w_capture = wr_req & w_addr_ok & w_ready;
  assign w_ovf_set = wr_req & w_addr_ok & ~w_ready;
  assign w_bad_set = wr_req & ~w_addr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < NUM_WR; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (w_capture[i]) begin
          r_valid[i] <= 1'b1;
          r_addr[i]  <= wr_addr_req[i*ADDR_W +: ADDR_W];
          r_data[i]  <= wr_data_req[i*DATA_W +: DATA_W];
        end else if (w_grant[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= '0;
      r_bad_addr <= '0;
    end else begin
      r_overflow <= (overflow_clr ? '0 : r_overflow) | w_ovf_set;
      r_bad_addr <= (overflow_clr ? '0 : r_bad_addr) | w_bad_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_we <= w_any_grant;
      if (w_any_grant) begin
        r_wr_addr   <= r_addr[w_grant_idx];
        r_wr_data   <= r_data[w_grant_idx];
        r_grant_idx <= w_grant_idx;
        r_rr_ptr    <= w_ptr_next;
      end
    end
  end

  assign wr_ready  = w_ready;
  assign overflow  = r_overflow;
  assign bad_addr  = r_bad_addr;
  assign we        = r_we;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign grant_idx = r_grant_idx;

endmodule
